full_adder: RTL and testbench
=============================

Name: full_adder

Overview:
- Registered ripple-carry adder built from gate-level full-adder bit cells; default configuration is the single-bit full adder (a + b + c_in -> sum, carry).
- Sits as a leaf arithmetic primitive in datapaths.
- Registers its result so it can be placed between pipeline stages without adding a combinational path to downstream logic.

Parameters:
- WIDTH, 1, operand width in bits (legal range 1..64).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- a  input  WIDTH  addend operand A, unsigned.
- b  input  WIDTH  addend operand B, unsigned.
- c_in  input  1  carry into bit 0.
- in_valid  input  1  operands and c_in are valid this cycle.
- sum  output  WIDTH  registered sum bits.
- carry  output  1  registered carry out of the MSB.
- out_valid  output  1  sum and carry hold a freshly computed result.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Bit cell i (gate level):
  - s[i] = a[i] XOR b[i] XOR c[i]
  - c[i+1] = (a[i] AND b[i]) OR (c[i] AND (a[i] XOR b[i]))
  - c[0] = c_in; carry-out = c[WIDTH].
- Cell chaining: plain ripple chain, no lookahead. Full WIDTH+1-bit result {carry, sum} = a + b + c_in, with no truncation and no overflow wrap beyond carry.
- Reset: on a rising edge with rst=1, sum <= 0, carry <= 0, out_valid <= 0. Reset overrides in_valid in the same cycle.
- Latency: exactly 1 cycle. If in_valid=1 at edge N (rst=0), sum/carry show the result of that edge's operands after edge N, and out_valid=1 for that cycle.
- If in_valid=0 at an edge (rst=0): sum and carry hold their previous values; out_valid <= 0.
- Back-to-back: a new operand set may be accepted every cycle. There is no backpressure and no ready signal.
- Reset mid-stream: an operand presented in the same cycle as rst=1 is discarded; its result never appears.
- Outputs are driven only by flops; no combinational path from inputs to outputs.
- Boundary cases:
  - all-ones a, all-ones b, c_in=1 -> sum all-ones, carry=1.
  - all-zero operands with c_in=1 -> sum=1, carry=0.
- X/Z on operands while in_valid=0 must not disturb held outputs.

Test Plan:
- WIDTH=1: assert rst one cycle -> sum=0, carry=0, out_valid=0. Then apply a=0, b=0, c_in=0 with in_valid=1 -> next cycle sum=0, carry=0, out_valid=1.
- WIDTH=1 sequence, one vector per cycle with in_valid=1:
  - (a,b,c_in) = (0,1,0) -> sum=1, carry=0
  - (1,1,1) -> sum=1, carry=1
  - (1,0,1) -> sum=0, carry=1
  - each result appears one cycle after it is applied.
- WIDTH=1 exhaustive: all 8 input combinations back-to-back -> {carry, sum} equals a+b+c_in each cycle.
- WIDTH=1 hold: apply (1,1,0) valid, then in_valid=0 for 3 cycles with inputs changing -> sum=0, carry=1 held; out_valid=1 then 0,0,0.
- WIDTH=4:
  - a=4'hF, b=4'hF, c_in=1 -> sum=4'hF, carry=1
  - a=4'h7, b=4'h8, c_in=1 -> sum=4'h0, carry=1 (full carry ripple)
  - a=4'h3, b=4'h4, c_in=0 -> sum=4'h7, carry=0.
- Reset mid-operation: previous result sum=1, carry=1; in the same cycle apply rst=1 with in_valid=1 and (1,1,1) -> next cycle sum=0, carry=0, out_valid=0. That operand's result never appears.

Source files
------------

// File: rtl/full_adder.sv
// Registered ripple-carry adder: gate-level full-adder bit cells chained LSB to MSB,
// with the WIDTH+1-bit result {carry, sum} captured in flops.
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             out_valid
);

    // Valid protocol: in_valid qualifies a, b and c_in for one edge; there is no
    // ready, so every qualified operand set is taken. out_valid pulses for exactly
    // the cycle after acceptance; otherwise sum/carry hold the last accepted result.

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] p;

    assign c[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign p[i]   = a[i] ^ b[i];
        assign s[i]   = p[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & p[i]);
    end

    // Result flops only load on accepted operands, so unknown operands while idle never reach them.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum   <= s;
                carry <= c[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Directed, table-driven bench for full_adder at WIDTH=1 and WIDTH=4.
module tb_full_adder;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       c_in;
        logic [3:0] sum;
        logic       carry;
    } vec_t;

    logic       clk;
    logic       rst;

    logic [0:0] a1, b1, sum1;
    logic       c_in1, in_valid1, carry1, out_valid1;

    logic [3:0] a4, b4, sum4;
    logic       c_in4, in_valid4, carry4, out_valid4;

    int n_vec;
    int n_miscompare;

    vec_t tab1[11];
    vec_t tab4[6];

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .a         (a1),
        .b         (b1),
        .c_in      (c_in1),
        .in_valid  (in_valid1),
        .sum       (sum1),
        .carry     (carry1),
        .out_valid (out_valid1)
    );

    full_adder #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .a         (a4),
        .b         (b4),
        .c_in      (c_in4),
        .in_valid  (in_valid4),
        .sum       (sum4),
        .carry     (carry4),
        .out_valid (out_valid4)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic v, input logic a, input logic b, input logic c);
        in_valid1 = v;
        a1        = a;
        b1        = b;
        c_in1     = c;
    endtask

    task automatic drive4(input logic v, input logic [3:0] a, input logic [3:0] b, input logic c);
        in_valid4 = v;
        a4        = a;
        b4        = b;
        c_in4     = c;
    endtask

    // scoreboard compare
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        n_vec        = 0;
        n_miscompare = 0;

        // WIDTH=1: plan sequence, then all 8 combinations
        tab1[0]  = '{a: 4'd0, b: 4'd1, c_in: 1'b0, sum: 4'd1, carry: 1'b0};
        tab1[1]  = '{a: 4'd1, b: 4'd1, c_in: 1'b1, sum: 4'd1, carry: 1'b1};
        tab1[2]  = '{a: 4'd1, b: 4'd0, c_in: 1'b1, sum: 4'd0, carry: 1'b1};
        tab1[3]  = '{a: 4'd0, b: 4'd0, c_in: 1'b0, sum: 4'd0, carry: 1'b0};
        tab1[4]  = '{a: 4'd0, b: 4'd0, c_in: 1'b1, sum: 4'd1, carry: 1'b0};
        tab1[5]  = '{a: 4'd0, b: 4'd1, c_in: 1'b0, sum: 4'd1, carry: 1'b0};
        tab1[6]  = '{a: 4'd0, b: 4'd1, c_in: 1'b1, sum: 4'd0, carry: 1'b1};
        tab1[7]  = '{a: 4'd1, b: 4'd0, c_in: 1'b0, sum: 4'd1, carry: 1'b0};
        tab1[8]  = '{a: 4'd1, b: 4'd0, c_in: 1'b1, sum: 4'd0, carry: 1'b1};
        tab1[9]  = '{a: 4'd1, b: 4'd1, c_in: 1'b0, sum: 4'd0, carry: 1'b1};
        tab1[10] = '{a: 4'd1, b: 4'd1, c_in: 1'b1, sum: 4'd1, carry: 1'b1};

        tab4[0] = '{a: 4'hF, b: 4'hF, c_in: 1'b1, sum: 4'hF, carry: 1'b1};
        tab4[1] = '{a: 4'h7, b: 4'h8, c_in: 1'b1, sum: 4'h0, carry: 1'b1};
        tab4[2] = '{a: 4'h3, b: 4'h4, c_in: 1'b0, sum: 4'h7, carry: 1'b0};
        tab4[3] = '{a: 4'h0, b: 4'h0, c_in: 1'b1, sum: 4'h1, carry: 1'b0};
        tab4[4] = '{a: 4'hA, b: 4'h5, c_in: 1'b0, sum: 4'hF, carry: 1'b0};
        tab4[5] = '{a: 4'hF, b: 4'h0, c_in: 1'b1, sum: 4'h0, carry: 1'b1};

        // reset
        rst = 1'b1;
        drive1(1'b0, 1'b0, 1'b0, 1'b0);
        drive4(1'b0, 4'h0, 4'h0, 1'b0);
        step();
        check("rst_w1_result", {6'd0, carry1, sum1}, 8'd0);
        check("rst_w1_valid", {7'd0, out_valid1}, 8'd0);
        check("rst_w4_result", {3'd0, carry4, sum4}, 8'd0);
        check("rst_w4_valid", {7'd0, out_valid4}, 8'd0);

        rst = 1'b0;
        drive1(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("w1_first_result", {6'd0, carry1, sum1}, 8'd0);
        check("w1_first_valid", {7'd0, out_valid1}, 8'd1);

        // WIDTH=1 back-to-back table
        for (int i = 0; i < 11; i++) begin
            drive1(1'b1, tab1[i].a[0], tab1[i].b[0], tab1[i].c_in);
            step();
            check($sformatf("w1_vec%0d_result", i), {6'd0, carry1, sum1},
                  {6'd0, tab1[i].carry, tab1[i].sum[0]});
            check($sformatf("w1_vec%0d_valid", i), {7'd0, out_valid1}, 8'd1);
        end

        // hold: idle cycles with wandering (even unknown) operands
        drive1(1'b1, 1'b1, 1'b1, 1'b0);
        step();
        check("w1_hold_load_result", {6'd0, carry1, sum1}, 8'b10);
        check("w1_hold_load_valid", {7'd0, out_valid1}, 8'd1);
        for (int i = 0; i < 3; i++) begin
            drive1(1'b0, 1'bx, 1'(i), ~1'(i));
            step();
            check($sformatf("w1_hold%0d_result", i), {6'd0, carry1, sum1}, 8'b10);
            check($sformatf("w1_hold%0d_valid", i), {7'd0, out_valid1}, 8'd0);
        end

        // WIDTH=4 table
        for (int i = 0; i < 6; i++) begin
            drive4(1'b1, tab4[i].a, tab4[i].b, tab4[i].c_in);
            step();
            check($sformatf("w4_vec%0d_result", i), {3'd0, carry4, sum4},
                  {3'd0, tab4[i].carry, tab4[i].sum});
            check($sformatf("w4_vec%0d_valid", i), {7'd0, out_valid4}, 8'd1);
        end
        drive4(1'b0, 4'h0, 4'h0, 1'b0);

        // reset mid-stream discards the concurrent operand
        drive1(1'b1, 1'b1, 1'b1, 1'b1);
        step();
        check("mid_pre_result", {6'd0, carry1, sum1}, 8'b11);
        rst = 1'b1;
        drive1(1'b1, 1'b1, 1'b1, 1'b1);
        step();
        check("mid_rst_result", {6'd0, carry1, sum1}, 8'd0);
        check("mid_rst_valid", {7'd0, out_valid1}, 8'd0);
        check("mid_rst_w4_result", {3'd0, carry4, sum4}, 8'd0);
        rst = 1'b0;
        drive1(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("mid_after_result", {6'd0, carry1, sum1}, 8'd0);
        check("mid_after_valid", {7'd0, out_valid1}, 8'd0);

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule
